// File: rtl/act_pkg.sv
// ---------------------------------------------------------------------------
// act_pkg
// Shared definitions for the elementwise activation stage.
//   act_mode_t : activation selector (ACT_RELU / ACT_LEAKY / ACT_RELU6 / ACT_BYPASS)
//   state_t    : controller states (IDLE / RUN / DONE)
//   clip_val   : ReLU6 ceiling (6 << frac_bits), saturated to the largest
//                positive signed value when it does not fit in data_width bits
// ---------------------------------------------------------------------------
package act_pkg;

    typedef enum logic [1:0] {
        ACT_RELU   = 2'd0,
        ACT_LEAKY  = 2'd1,
        ACT_RELU6  = 2'd2,
        ACT_BYPASS = 2'd3
    } act_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // The value 6 needs three magnitude bits, so 6 << frac_bits fits a signed
    // word only when frac_bits + 3 <= data_width - 1.
    function automatic logic [63:0] clip_val(input int unsigned data_width,
                                             input int unsigned frac_bits);
        if (frac_bits + 3 <= data_width - 1) begin
            return 64'd6 << frac_bits;
        end
        return (64'd1 << (data_width - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/act_lane.sv
// ---------------------------------------------------------------------------
// act_lane
// Purely combinational single-element activation.
// Ports:
//   e      in  DATA_WIDTH  signed fixed-point input element
//   mode   in  act_mode_t  activation selector
//   y      out DATA_WIDTH  activated element
//   is_neg out 1           sign bit of e (zero is not negative)
// ---------------------------------------------------------------------------
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic [DATA_WIDTH-1:0] e,
    input  act_mode_t             mode,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  is_neg
);

    localparam logic signed [DATA_WIDTH-1:0] CLIP =
        DATA_WIDTH'(clip_val(DATA_WIDTH, FRAC_BITS));

    logic signed [DATA_WIDTH-1:0] es;
    logic signed [DATA_WIDTH-1:0] leak;

    assign es     = e;
    assign is_neg = e[DATA_WIDTH-1];
    // Arithmetic shift floors toward -inf and can only shrink magnitude.
    assign leak   = es >>> LEAK_SHIFT;

    always_comb begin
        y = e;
        unique case (mode)
            ACT_RELU:   y = is_neg ? '0 : e;
            ACT_LEAKY:  y = is_neg ? leak : e;
            ACT_RELU6: begin
                if (is_neg) begin
                    y = '0;
                end else if (es > CLIP) begin
                    y = CLIP;
                end else begin
                    y = e;
                end
            end
            ACT_BYPASS: y = e;
            default:    y = e;
        endcase
    end

endmodule

// File: rtl/activation_unit.sv
// ---------------------------------------------------------------------------
// activation_unit
// Elementwise activation stage. Snapshots NOF_INPUTS words on an accepted
// start_flag and processes LANES words per cycle from the snapshot.
// Ports:
//   clk        in  1                      rising-edge clock
//   rst_n      in  1                      asynchronous active-low reset
//   x          in  NOF_INPUTS*DATA_WIDTH  packed input vector
//   mode       in  2                      0 ReLU, 1 leaky, 2 ReLU6, 3 bypass
//   start_flag in  1                      request, accepted in IDLE or DONE
//   x_act      out NOF_INPUTS*DATA_WIDTH  registered result vector
//   busy       out 1                      high while running
//   over_flag  out 1                      high in DONE until next accept
//   neg_count  out $clog2(NOF_INPUTS+1)   count of negative elements
// ---------------------------------------------------------------------------
module activation_unit
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NOF_INPUTS = 7,
    parameter int LANES      = 1,
    parameter int FRAC_BITS  = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NOF_INPUTS*DATA_WIDTH-1:0] x,
    input  logic [1:0]                       mode,
    input  logic                             start_flag,
    output logic [NOF_INPUTS*DATA_WIDTH-1:0] x_act,
    output logic                             busy,
    output logic                             over_flag,
    output logic [$clog2(NOF_INPUTS+1)-1:0]  neg_count
);

    localparam int unsigned N     = NOF_INPUTS;
    localparam int unsigned L     = LANES;
    localparam int unsigned CNT_W = $clog2(NOF_INPUTS + 1);
    localparam int unsigned IDX_W = $clog2(NOF_INPUTS + LANES + 1);

    state_t                 state;
    act_mode_t              mode_q;
    logic [IDX_W-1:0]       index;
    logic [DATA_WIDTH-1:0]  snap     [NOF_INPUTS];

    logic [DATA_WIDTH-1:0]  lane_in  [LANES];
    logic [DATA_WIDTH-1:0]  lane_out [LANES];
    logic [LANES-1:0]       lane_neg;
    logic [LANES-1:0]       lane_valid;
    logic [CNT_W-1:0]       chunk_neg;
    logic                   last_chunk;

    // Lane l works on element index+l; the mux is written as a compare
    // against every constant element position so that lanes past the end
    // of the vector simply see no match and stay masked.
    always_comb begin
        chunk_neg = '0;
        for (int unsigned l = 0; l < L; l++) begin
            lane_in[l]    = '0;
            lane_valid[l] = (32'(index) + l) < N;
            for (int unsigned k = 0; k < N; k++) begin
                if (32'(index) + l == k) begin
                    lane_in[l] = snap[k];
                end
            end
            if (lane_valid[l] && lane_neg[l]) begin
                chunk_neg = chunk_neg + CNT_W'(1);
            end
        end
        last_chunk = (32'(index) + L) >= N;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .e      (lane_in[g]),
            .mode   (mode_q),
            .y      (lane_out[g]),
            .is_neg (lane_neg[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= ACT_RELU;
            index     <= '0;
            x_act     <= '0;
            busy      <= 1'b0;
            over_flag <= 1'b0;
            neg_count <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                snap[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start_flag) begin
                        for (int unsigned k = 0; k < N; k++) begin
                            snap[k] <= x[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                        mode_q    <= act_mode_t'(mode);
                        index     <= '0;
                        neg_count <= '0;
                        over_flag <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    for (int unsigned k = 0; k < N; k++) begin
                        for (int unsigned l = 0; l < L; l++) begin
                            if (lane_valid[l] && (32'(index) + l == k)) begin
                                x_act[k*DATA_WIDTH +: DATA_WIDTH] <= lane_out[l];
                            end
                        end
                    end
                    neg_count <= neg_count + chunk_neg;
                    if (last_chunk) begin
                        busy      <= 1'b0;
                        over_flag <= 1'b1;
                        state     <= DONE;
                    end else begin
                        index <= index + IDX_W'(L);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_activation_unit.sv
// ---------------------------------------------------------------------------
// tb_activation_unit
// Two instances share stimulus: dut_a uses defaults (LANES=1, FRAC_BITS=8),
// dut_b uses LANES=3, FRAC_BITS=13 (saturated ReLU6 ceiling).
// ---------------------------------------------------------------------------
module tb_activation_unit;

    localparam int DW = 16;
    localparam int N  = 7;
    localparam int LS = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] x;
    logic [1:0]      mode;
    logic            start_flag;

    logic [N*DW-1:0] xa_a, xa_b;
    logic            busy_a, busy_b, ov_a, ov_b;
    logic [2:0]      nc_a, nc_b;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    activation_unit dut_a (
        .clk(clk), .rst_n(rst_n), .x(x), .mode(mode), .start_flag(start_flag),
        .x_act(xa_a), .busy(busy_a), .over_flag(ov_a), .neg_count(nc_a)
    );

    activation_unit #(
        .DATA_WIDTH(16), .NOF_INPUTS(7), .LANES(3), .FRAC_BITS(13), .LEAK_SHIFT(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .x(x), .mode(mode), .start_flag(start_flag),
        .x_act(xa_b), .busy(busy_b), .over_flag(ov_b), .neg_count(nc_b)
    );

    typedef struct {
        logic [N*DW-1:0] xv;
        int              neg;
        int unsigned     acc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [N*DW-1:0] act,
                         input logic [N*DW-1:0] req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference: plain integer arithmetic on the element value.
    function automatic logic [DW-1:0] ref_elem(input logic [DW-1:0] w, input int m,
                                               input int fb);
        int v;
        int clip;
        int r;
        int d;
        v    = int'($signed(w));
        d    = 1 << LS;
        clip = 6 * (1 << fb);
        if (clip > 32767) clip = 32767;
        case (m)
            0:       r = (v < 0) ? 0 : v;
            1:       r = (v < 0) ? (v - (d - 1)) / d : v;  // floor division
            2:       r = (v < 0) ? 0 : ((v > clip) ? clip : v);
            default: r = v;
        endcase
        return r[DW-1:0];
    endfunction

    function automatic logic [N*DW-1:0] ref_vec(input logic [N*DW-1:0] v, input int m,
                                                input int fb);
        logic [N*DW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = ref_elem(v[k*DW +: DW], m, fb);
        return r;
    endfunction

    function automatic int ref_neg(input logic [N*DW-1:0] v);
        int n;
        n = 0;
        for (int k = 0; k < N; k++) if (int'($signed(v[k*DW +: DW])) < 0) n++;
        return n;
    endfunction

    function automatic logic [N*DW-1:0] pack7(input int e [N]);
        logic [N*DW-1:0] v;
        int t;
        for (int k = 0; k < N; k++) begin
            t = e[k];
            v[k*DW +: DW] = t[DW-1:0];
        end
        return v;
    endfunction

    function automatic logic [N*DW-1:0] rand_vec();
        logic [N*DW-1:0] v;
        logic [31:0] r;
        for (int k = 0; k < N; k++) begin
            r = $urandom;
            case ($urandom_range(0, 5))
                0:       v[k*DW +: DW] = 16'h8000;
                1:       v[k*DW +: DW] = 16'h7FFF;
                2:       v[k*DW +: DW] = 16'h0000;
                3:       v[k*DW +: DW] = 16'h0600 + 16'(r[2:0]) - 16'd4;
                default: v[k*DW +: DW] = r[DW-1:0];
            endcase
        end
        return v;
    endfunction

    // Drive one start pulse while both instances are idle/done and record
    // the expected responses. Returns at the negedge after the accept edge.
    task automatic issue(input logic [N*DW-1:0] v, input logic [1:0] m);
        exp_t ea;
        exp_t eb;
        @(negedge clk);
        x          = v;
        mode       = m;
        start_flag = 1'b1;
        ea.xv  = ref_vec(v, int'(m), 8);
        ea.neg = ref_neg(v);
        ea.acc = cyc + 1;
        eb.xv  = ref_vec(v, int'(m), 13);
        eb.neg = ea.neg;
        eb.acc = cyc + 1;
        q_a.push_back(ea);
        q_b.push_back(eb);
        @(negedge clk);
        start_flag = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (i < 50 && !(ov_a && ov_b)) begin
            @(negedge clk);
            i++;
        end
        check("done_within_budget", {111'd0, ov_a && ov_b}, 1);
    endtask

    initial begin : mon_a
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ov_a && !prev) begin
                if (q_a.size() == 0) begin
                    checks++;
                    $display("FAIL a_unexpected_done: got over_flag=1 expected no completion");
                end else begin
                    e = q_a.pop_front();
                    check("a_x_act", xa_a, e.xv);
                    check("a_neg_count", {109'd0, nc_a}, e.neg);
                    check("a_latency", cyc - e.acc, 7);
                end
            end
            prev = ov_a;
        end
    end

    initial begin : mon_b
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ov_b && !prev) begin
                if (q_b.size() == 0) begin
                    checks++;
                    $display("FAIL b_unexpected_done: got over_flag=1 expected no completion");
                end else begin
                    e = q_b.pop_front();
                    check("b_x_act", xa_b, e.xv);
                    check("b_neg_count", {109'd0, nc_b}, e.neg);
                    check("b_latency", cyc - e.acc, 3);
                end
            end
            prev = ov_b;
        end
    end

    initial begin : stim
        logic [N*DW-1:0] v;
        rst_n      = 1'b0;
        x          = '0;
        mode       = 2'd0;
        start_flag = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_x_act_a", xa_a, '0);
        check("reset_x_act_b", xa_b, '0);
        check("reset_flags", {106'd0, busy_a, busy_b, ov_a, ov_b, 2'b00},
              '0);
        check("reset_neg", {106'd0, nc_a, nc_b}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: ReLU reference vector
        issue(pack7('{1, -1, 32'h7FFF, 32'hFFFF8000, 0, 5, -300}), 2'd0);
        wait_done();
        check("relu_vec_const", xa_a,
              pack7('{1, 0, 32'h7FFF, 0, 0, 5, 0}));
        check("relu_neg_const", {109'd0, nc_a}, 3);

        // Directed: leaky
        issue(pack7('{-8, -1, -16, 40, 0, -32768, 7}), 2'd1);
        wait_done();
        check("leaky_vec_const", xa_a,
              pack7('{-1, -1, -2, 40, 0, -4096, 7}));

        // Directed: ReLU6 (dut_b ceiling saturates to 0x7FFF)
        issue(pack7('{32'h0700, 32'h05FF, -5, 32'h0600, 32'h7FFF, 32'h6000, 1}), 2'd2);
        wait_done();
        check("relu6_vec_const", xa_a,
              pack7('{32'h0600, 32'h05FF, 0, 32'h0600, 32'h0600, 32'h0600, 1}));

        // Start re-pulsed in RUN and inputs changed after accept
        issue(rand_vec(), 2'($urandom_range(0, 3)));
        x          = rand_vec();
        mode       = 2'($urandom_range(0, 3));
        start_flag = 1'b1;
        @(negedge clk);
        start_flag = 1'b0;
        x          = rand_vec();
        wait_done();

        // Restart from DONE clears over_flag for the whole run
        issue(rand_vec(), 2'd3);
        check("restart_flags", {108'd0, busy_a, busy_b, ov_a, ov_b}, 112'b1100);
        @(negedge clk);
        check("restart_ov_b_held_low", {111'd0, ov_b}, 0);
        wait_done();

        // Asynchronous reset in RUN cycle 2, between edges
        issue(rand_vec(), 2'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_x_act_a", xa_a, '0);
        check("abort_x_act_b", xa_b, '0);
        check("abort_flags", {106'd0, busy_a, busy_b, ov_a, ov_b, nc_a[0], nc_b[0]}, '0);
        check("abort_neg", {106'd0, nc_a, nc_b}, '0);
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        issue(rand_vec(), 2'd2);
        wait_done();

        // Randomized runs
        for (int r = 0; r < 24; r++) begin
            v = rand_vec();
            issue(v, 2'($urandom_range(0, 3)));
            wait_done();
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 112'(q_a.size() + q_b.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
